// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage, including forwarding
// inputs, the stall request and the architectural HI/LO registers.
interface ex_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             id_ex_valid;
    logic [3:0]       id_ex_alu_op;
    logic [WIDTH-1:0] id_ex_rs_data;
    logic [WIDTH-1:0] id_ex_rt_data;
    logic [WIDTH-1:0] id_ex_imm;
    logic             id_ex_alu_src;
    logic             id_ex_reg_write;
    logic             id_ex_mem_read;
    logic             id_ex_mem_write;
    logic             id_ex_mem_to_reg;
    logic [4:0]       id_ex_write_reg;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [WIDTH-1:0] ex_mem_fwd_data;
    logic [WIDTH-1:0] mem_wb_fwd_data;
    logic             flush;

    logic             ex_busy;
    logic             ex_mem_valid;
    logic             ex_mem_reg_write;
    logic             ex_mem_mem_read;
    logic             ex_mem_mem_write;
    logic             ex_mem_mem_to_reg;
    logic [4:0]       ex_mem_write_reg;
    logic [WIDTH-1:0] ex_mem_alu_result;
    logic [WIDTH-1:0] ex_mem_store_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Upstream pipeline side: drives ID/EX and forwarding, observes EX/MEM.
    modport master (
        output id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_mem_to_reg, id_ex_write_reg, forward_a, forward_b,
               ex_mem_fwd_data, mem_wb_fwd_data, flush,
        input  ex_busy, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
               ex_mem_mem_to_reg, ex_mem_write_reg, ex_mem_alu_result, ex_mem_store_data,
               hi, lo
    );

    // Execute stage side.
    modport slave (
        input  id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
               id_ex_alu_src, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_mem_to_reg, id_ex_write_reg, forward_a, forward_b,
               ex_mem_fwd_data, mem_wb_fwd_data, flush,
        output ex_busy, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
               ex_mem_mem_to_reg, ex_mem_write_reg, ex_mem_alu_result, ex_mem_store_data,
               hi, lo
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding muxes, single-cycle ALU, EX/MEM
// register, and an iterative one-bit-per-cycle MULTU/DIVU engine feeding HI/LO.
module ex_stage #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] eng_op_q, eng_op_d;    // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;    // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;    // multiplier shifting out / quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] store_data_q, store_data_d;

    logic [WIDTH-1:0] op_a, fwd_rt, op_b, alu_res;
    logic [4:0]       shamt;
    logic             hilo_class, busy, load, is_muldiv;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    // Forwarding muxes, stall decision and ALU.
    always_comb begin
        unique case (bus.forward_a)
            2'b10:   op_a = bus.ex_mem_fwd_data;
            2'b01:   op_a = bus.mem_wb_fwd_data;
            default: op_a = bus.id_ex_rs_data;
        endcase
        unique case (bus.forward_b)
            2'b10:   fwd_rt = bus.ex_mem_fwd_data;
            2'b01:   fwd_rt = bus.mem_wb_fwd_data;
            default: fwd_rt = bus.id_ex_rt_data;
        endcase
        op_b  = bus.id_ex_alu_src ? bus.id_ex_imm : fwd_rt;
        shamt = bus.id_ex_imm[10:6];

        hilo_class = bus.id_ex_valid && (bus.id_ex_alu_op[3:2] == 2'b11);
        busy       = (state_q != StIdle) && hilo_class;
        load       = bus.id_ex_valid && !bus.flush && !busy;
        is_muldiv  = (bus.id_ex_alu_op == 4'hC) || (bus.id_ex_alu_op == 4'hD);

        unique case (bus.id_ex_alu_op)
            4'h0: alu_res = op_a + op_b;
            4'h1: alu_res = op_a - op_b;
            4'h2: alu_res = op_a & op_b;
            4'h3: alu_res = op_a | op_b;
            4'h4: alu_res = op_a ^ op_b;
            4'h5: alu_res = ~(op_a | op_b);
            4'h6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'h7: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            4'h8: alu_res = op_b << shamt;
            4'h9: alu_res = op_b >> shamt;
            4'hA: alu_res = $unsigned($signed(op_b) >>> shamt);
            4'hB: alu_res = {op_b[15:0], {(WIDTH-16){1'b0}}};
            4'hE: alu_res = hi_q;
            4'hF: alu_res = lo_q;
            default: alu_res = '0;  // MULTU/DIVU write nothing through EX/MEM
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, eng_op_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, eng_op_q};
        if (state_q == StDiv) begin
            // Divisor of zero never borrows, giving quotient all ones and remainder A.
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Engine FSM next state and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eng_op_d = eng_op_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (load && bus.id_ex_alu_op == 4'hC) begin
                    state_d  = StMul;
                    cnt_d    = '0;
                    eng_op_d = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                end else if (load && bus.id_ex_alu_op == 4'hD) begin
                    state_d  = StDiv;
                    cnt_d    = '0;
                    eng_op_d = op_b;
                    acc_hi_d = '0;
                    acc_lo_d = op_a;
                end
            end
            StMul, StDiv: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // EX/MEM register next state: bubble unless a live, unstalled, unflushed op.
    always_comb begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        write_reg_d  = '0;
        alu_result_d = '0;
        store_data_d = '0;
        if (load) begin
            valid_d      = 1'b1;
            reg_write_d  = bus.id_ex_reg_write && !is_muldiv;
            mem_read_d   = bus.id_ex_mem_read;
            mem_write_d  = bus.id_ex_mem_write;
            mem_to_reg_d = bus.id_ex_mem_to_reg;
            write_reg_d  = bus.id_ex_write_reg;
            alu_result_d = alu_res;
            store_data_d = fwd_rt;
        end
    end

    // All state registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            eng_op_q     <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            write_reg_q  <= '0;
            alu_result_q <= '0;
            store_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            eng_op_q     <= eng_op_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            write_reg_q  <= write_reg_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
        end
    end

    assign bus.ex_busy           = busy;
    assign bus.ex_mem_valid      = valid_q;
    assign bus.ex_mem_reg_write  = reg_write_q;
    assign bus.ex_mem_mem_read   = mem_read_q;
    assign bus.ex_mem_mem_write  = mem_write_q;
    assign bus.ex_mem_mem_to_reg = mem_to_reg_q;
    assign bus.ex_mem_write_reg  = write_reg_q;
    assign bus.ex_mem_alu_result = alu_result_q;
    assign bus.ex_mem_store_data = store_data_q;
    assign bus.hi                = hi_q;
    assign bus.lo                = lo_q;
endmodule
